// File: rtl/if_mem_sram_arbiter.sv
// Arbitrates the shared instruction/data SRAM between the IF and MEM stages.
// MEM wins over IF; each access takes ACCESS_CYCLES cycles plus one idle bubble.
module if_mem_sram_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_inst,
    output logic        if_valid,
    output logic        pc_keep,
    input  logic        flush,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_stall,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_addr;
    logic [15:0]   r_wdata;
    logic [15:0]   r_rdata_hold;
    logic          w_last;
    logic          w_grant;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Count only while staying inside one access; any exit or entry restarts at 0.
            if (r_state != IDLE && w_next != IDLE)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_wr) begin
                    w_next  = MEM_WR;
                    w_grant = 1'b1;
                end else if (mem_rd) begin
                    w_next  = MEM_RD;
                    w_grant = 1'b1;
                end else if (if_req && !flush) begin
                    w_next  = IF_ACC;
                    w_grant = 1'b1;
                end
            end
            IF_ACC: begin
                if (flush || w_last)
                    w_next = IDLE;
            end
            MEM_RD, MEM_WR: begin
                if (w_last)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata_hold <= '0;
        end else begin
            if (w_grant) begin
                r_addr  <= (w_next == IF_ACC) ? if_addr : mem_addr;
                r_wdata <= mem_wdata;
            end
            if (r_state == MEM_RD && w_last)
                r_rdata_hold <= sram_dq_i;
        end
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        if_valid   = 1'b0;
        mem_done   = 1'b0;
        mem_rdata  = r_rdata_hold;
        case (r_state)
            IF_ACC: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if_valid  = w_last && !flush;
            end
            MEM_RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                mem_done  = w_last;
                if (w_last)
                    mem_rdata = sram_dq_i;
            end
            MEM_WR: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                // Release we_n in the last cycle so data is held past the write edge.
                sram_we_n  = !((ACCESS_CYCLES == 1) || !w_last);
                mem_done   = w_last;
            end
            default: ;
        endcase
    end

    assign if_inst   = if_valid ? sram_dq_i : 16'h0800;
    assign pc_keep   = if_req & ~if_valid & ~flush;
    assign mem_stall = (mem_rd | mem_wr) & ~mem_done;
    assign sram_addr = r_addr;
    assign sram_dq_o = r_wdata;
endmodule

// File: tb/tb_if_mem_sram_arbiter.sv
// Bench for if_mem_sram_arbiter: two instances (2- and 3-cycle accesses) share
// one stimulus stream and are compared each cycle against a transaction-level model.
module tb_if_mem_sram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, flush, mem_rd, mem_wr;
    logic [15:0] if_addr, mem_addr, mem_wdata, sram_dq_i;

    logic [15:0] if_inst[2], mem_rdata[2], sram_addr[2], sram_dq_o[2];
    logic        if_valid[2], pc_keep[2], mem_done[2], mem_stall[2];
    logic        sram_dq_oe[2], sram_ce_n[2], sram_oe_n[2], sram_we_n[2];

    if_mem_sram_arbiter #(.ACCESS_CYCLES(2)) u_dut_n2 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_inst(if_inst[0]), .if_valid(if_valid[0]), .pc_keep(pc_keep[0]),
        .flush(flush), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata[0]), .mem_done(mem_done[0]),
        .mem_stall(mem_stall[0]), .sram_addr(sram_addr[0]), .sram_dq_o(sram_dq_o[0]),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe[0]), .sram_ce_n(sram_ce_n[0]),
        .sram_oe_n(sram_oe_n[0]), .sram_we_n(sram_we_n[0])
    );

    if_mem_sram_arbiter #(.ACCESS_CYCLES(3)) u_dut_n3 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_inst(if_inst[1]), .if_valid(if_valid[1]), .pc_keep(pc_keep[1]),
        .flush(flush), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata[1]), .mem_done(mem_done[1]),
        .mem_stall(mem_stall[1]), .sram_addr(sram_addr[1]), .sram_dq_o(sram_dq_o[1]),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe[1]), .sram_ce_n(sram_ce_n[1]),
        .sram_oe_n(sram_oe_n[1]), .sram_we_n(sram_we_n[1])
    );

    int checks = 0;
    int failures = 0;

    // Model: which transaction is in flight and which of its N cycles we are in.
    localparam int OP_NONE = 0, OP_FETCH = 1, OP_LOAD = 2, OP_STORE = 3;
    int          m_op[2];
    int          m_pos[2];
    logic [15:0] m_addr[2], m_wdata[2], m_hold[2];

    function automatic int n_of(input int inst);
        return (inst == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n_of(inst), obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_op[i] = OP_NONE; m_pos[i] = 0;
            m_addr[i] = 16'h0; m_wdata[i] = 16'h0; m_hold[i] = 16'h0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int n;
            bit act, last, e_ifv, e_done, e_rd_last, e_we;
            n         = n_of(i);
            act       = (m_op[i] != OP_NONE);
            last      = act && (m_pos[i] == n);
            e_ifv     = (m_op[i] == OP_FETCH) && last && !flush;
            e_done    = (m_op[i] == OP_LOAD || m_op[i] == OP_STORE) && last;
            e_rd_last = (m_op[i] == OP_LOAD) && last;
            e_we      = (m_op[i] == OP_STORE) && ((m_pos[i] < n) || (n == 1));
            chk("sram_ce_n", i, sram_ce_n[i], !act);
            chk("sram_oe_n", i, sram_oe_n[i], !(m_op[i] == OP_FETCH || m_op[i] == OP_LOAD));
            chk("sram_we_n", i, sram_we_n[i], !e_we);
            chk("sram_dq_oe", i, sram_dq_oe[i], m_op[i] == OP_STORE);
            chk("sram_addr", i, sram_addr[i], m_addr[i]);
            if (m_op[i] == OP_STORE)
                chk("sram_dq_o", i, sram_dq_o[i], m_wdata[i]);
            chk("if_valid", i, if_valid[i], e_ifv);
            chk("if_inst", i, if_inst[i], e_ifv ? sram_dq_i : 16'h0800);
            chk("pc_keep", i, pc_keep[i], if_req && !e_ifv && !flush);
            chk("mem_done", i, mem_done[i], e_done);
            chk("mem_rdata", i, mem_rdata[i], e_rd_last ? sram_dq_i : m_hold[i]);
            chk("mem_stall", i, mem_stall[i], (mem_rd || mem_wr) && !e_done);
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_op[i] = OP_NONE; m_pos[i] = 0;
                m_addr[i] = 16'h0; m_wdata[i] = 16'h0; m_hold[i] = 16'h0;
            end else if (m_op[i] == OP_NONE) begin
                if (mem_wr || mem_rd || (if_req && !flush)) begin
                    m_op[i]    = mem_wr ? OP_STORE : (mem_rd ? OP_LOAD : OP_FETCH);
                    m_pos[i]   = 1;
                    m_addr[i]  = (m_op[i] == OP_FETCH) ? if_addr : mem_addr;
                    m_wdata[i] = mem_wdata;
                end
            end else if (m_op[i] == OP_FETCH && flush) begin
                m_op[i] = OP_NONE; m_pos[i] = 0;
            end else if (m_pos[i] == n_of(i)) begin
                if (m_op[i] == OP_LOAD)
                    m_hold[i] = sram_dq_i;
                m_op[i] = OP_NONE; m_pos[i] = 0;
            end else begin
                m_pos[i] = m_pos[i] + 1;
            end
        end
    endtask

    task automatic step_check();
        @(negedge clk);
        check_all();
    endtask

    task automatic step_adv();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        step_check();
        step_adv();
    endtask

    task automatic idle(input int k);
        if_req = 1'b0; flush = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        repeat (k) cyc();
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; flush = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        if_addr = 16'h0; mem_addr = 16'h0; mem_wdata = 16'h0; sram_dq_i = 16'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(2);

        // Fetch only
        if_req = 1'b1; if_addr = 16'h0010; sram_dq_i = 16'h4A05;
        step_check(); chk("fetch_pc_keep_c0", 0, pc_keep[0], 1'b1); step_adv();
        step_check(); chk("fetch_pc_keep_c1", 0, pc_keep[0], 1'b1);
        chk("fetch_addr_c1", 0, sram_addr[0], 16'h0010); step_adv();
        step_check(); chk("fetch_valid_c2", 0, if_valid[0], 1'b1);
        chk("fetch_inst_c2", 0, if_inst[0], 16'h4A05);
        chk("fetch_pc_keep_c2", 0, pc_keep[0], 1'b0); step_adv();
        if_req = 1'b0;
        step_check(); chk("fetch_idle_c3", 0, sram_ce_n[0], 1'b1); step_adv();
        idle(4);

        // Contention: MEM read beats fetch
        if_req = 1'b1; mem_rd = 1'b1; mem_addr = 16'h8000; if_addr = 16'h0020; sram_dq_i = 16'h1234;
        cyc();
        step_check(); chk("cont_addr_c1", 0, sram_addr[0], 16'h8000); step_adv();
        step_check(); chk("cont_done_c2", 0, mem_done[0], 1'b1);
        chk("cont_rdata_c2", 0, mem_rdata[0], 16'h1234); step_adv();
        mem_rd = 1'b0;
        step_check(); chk("cont_pc_keep_c3", 0, pc_keep[0], 1'b1); step_adv();
        step_check(); chk("cont_pc_keep_c4", 0, pc_keep[0], 1'b1); step_adv();
        step_check(); chk("cont_if_valid_c5", 0, if_valid[0], 1'b1); step_adv();
        if_req = 1'b0;
        idle(5);

        // Store with a 3-cycle access
        mem_wr = 1'b1; mem_addr = 16'h00FF; mem_wdata = 16'hBEEF;
        step_check(); chk("store_stall_c0", 1, mem_stall[1], 1'b1); step_adv();
        step_check(); chk("store_we_c1", 1, sram_we_n[1], 1'b0);
        chk("store_oe_c1", 1, sram_dq_oe[1], 1'b1); step_adv();
        step_check(); chk("store_we_c2", 1, sram_we_n[1], 1'b0);
        chk("store_stall_c2", 1, mem_stall[1], 1'b1); step_adv();
        step_check(); chk("store_we_c3", 1, sram_we_n[1], 1'b1);
        chk("store_oe_c3", 1, sram_dq_oe[1], 1'b1);
        chk("store_stall_c3", 1, mem_stall[1], 1'b0);
        chk("store_data_c3", 1, sram_dq_o[1], 16'hBEEF); step_adv();
        idle(5);

        // Flush during fetch
        if_req = 1'b1; if_addr = 16'h0100; sram_dq_i = 16'h5A5A;
        cyc();
        flush = 1'b1; if_addr = 16'h0200;
        step_check(); chk("flush_valid_c1", 0, if_valid[0], 1'b0);
        chk("flush_pc_keep_c1", 0, pc_keep[0], 1'b0);
        chk("flush_inst_c1", 0, if_inst[0], 16'h0800); step_adv();
        flush = 1'b0;
        step_check(); chk("flush_idle_c2", 0, sram_ce_n[0], 1'b1); step_adv();
        step_check(); chk("flush_newaddr_c3", 0, sram_addr[0], 16'h0200); step_adv();
        idle(5);

        // Read and write together: a write, no capture
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0033; mem_wdata = 16'h5555; sram_dq_i = 16'hABCD;
        cyc();
        step_check(); chk("rdwr_we_c1", 0, sram_we_n[0], 1'b0); step_adv();
        cyc(); cyc();
        idle(5);
        step_check(); chk("rdwr_hold_n2", 0, mem_rdata[0], 16'h1234);
        chk("rdwr_hold_n3", 1, mem_rdata[1], 16'h1234); step_adv();

        // Reset in the middle of a store
        mem_wr = 1'b1; mem_addr = 16'h0444; mem_wdata = 16'h7777;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; mem_wr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) step_check();
            chk("rst_we_n", i, sram_we_n[i], 1'b1);
            chk("rst_dq_oe", i, sram_dq_oe[i], 1'b0);
            chk("rst_done", i, mem_done[i], 1'b0);
            chk("rst_addr", i, sram_addr[i], 16'h0000);
        end
        step_adv();
        idle(3);

        // Random traffic
        repeat (600) begin
            rst       = ($urandom_range(0, 63) == 0);
            if_req    = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 7) == 0);
            mem_rd    = ($urandom_range(0, 4) == 0);
            mem_wr    = ($urandom_range(0, 5) == 0);
            if_addr   = 16'($urandom);
            mem_addr  = 16'($urandom);
            mem_wdata = 16'($urandom);
            sram_dq_i = 16'($urandom);
            cyc();
        end
        rst = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_mem_sram_arbiter.md
Name: if_mem_sram_arbiter

Overview:
- Shares the single instruction/data SRAM between the IF stage (fetch at current PC) and the MEM stage (load/store) of the 16-bit pipelined CPU.
- Sequences multi-cycle SRAM accesses and gives MEM priority over IF on the structural hazard.
- Drives the PC-hold signal (pc_keep) and the MEM-stage stall.
- Honours mispredict flushes, so the PC register can take the corrected target.

Parameters:
- ACCESS_CYCLES, 2, number of cycles each SRAM access occupies; legal range 1..8.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF stage wants the instruction at if_addr
- if_addr  in  16  fetch address (current PC)
- if_inst  out  16  fetched instruction; equals sram_dq_i while if_valid=1, else NOP 16'h0800
- if_valid  out  1  instruction delivered this cycle
- pc_keep  out  1  hold the PC register this cycle
- flush  in  1  branch mispredict; the PC is being redirected this cycle
- mem_rd  in  1  load request
- mem_wr  in  1  store request
- mem_addr  in  16  load/store address
- mem_wdata  in  16  store data
- mem_rdata  out  16  load data
- mem_done  out  1  MEM access completes this cycle
- mem_stall  out  1  stall the MEM stage and everything upstream
- sram_addr  out  16  SRAM address
- sram_dq_o  out  16  SRAM write data
- sram_dq_i  in  16  SRAM read data
- sram_dq_oe  out  1  drive the data bus
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low

Behaviour:
- States: IDLE, IF_ACC, MEM_RD, MEM_WR. A counter cnt counts the cycles within an access, 0..ACCESS_CYCLES-1.
- Arbitration happens in IDLE only, in this priority order:
  - mem_wr=1: go to MEM_WR.
  - else mem_rd=1: go to MEM_RD. If mem_rd and mem_wr are both 1, the access is a write.
  - else if_req=1 and flush=0: go to IF_ACC.
  - else stay in IDLE.
- On grant, register sram_addr (if_addr or mem_addr) and sram_dq_o (mem_wdata). Input changes during the access are ignored.
- Access timing:
  - The request is sampled in IDLE in cycle 0.
  - Access states occupy cycles 1..N, where N=ACCESS_CYCLES.
  - Cycle N is the last cycle. After it, the state always returns to IDLE, giving one bubble.
  - Throughput is one access per N+1 cycles.
- Strobes:
  - sram_ce_n=0 in every access state.
  - sram_oe_n=0 in MEM_RD and IF_ACC.
  - In MEM_WR, sram_dq_oe=1 for all cycles.
  - In MEM_WR, sram_we_n=0 in cycles 1..N-1; it returns to 1 in the last cycle for data hold. If N=1, sram_we_n=0 in that single cycle.
  - In IDLE, all strobes are 1 and sram_dq_oe=0.
- Last cycle outputs (combinational):
  - IF_ACC: if_valid=1 unless flush=1.
  - MEM_RD and MEM_WR: mem_done=1.
  - MEM_RD: mem_rdata=sram_dq_i, and the value is captured into a holding register at the closing edge.
  - Outside a MEM_RD last cycle, mem_rdata shows the holding register.
- pc_keep = if_req & ~if_valid & ~flush. Forcing it to 0 on flush lets the redirect load into the PC.
- mem_stall = (mem_rd | mem_wr) & ~mem_done.
- Flush:
  - In IF_ACC, any cycle: abort the access. Next state is IDLE, if_valid is suppressed and if_inst shows NOP.
  - In IDLE: blocks the IF grant that cycle.
  - MEM states are unaffected.
- Requester dropping its request mid-access: the access still completes. A read result is still captured.
- Reset (synchronous, any state, including mid-access), values from the next edge:
  - State IDLE, cnt=0.
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_dq_oe=0.
  - sram_addr=0, sram_dq_o=0, mem_rdata hold register=0.
  - if_valid=0, mem_done=0.
  - An aborted write must not complete: we_n goes high at the reset edge.
- Counter arithmetic: cnt increments by 1 per access cycle. The last cycle is cnt==ACCESS_CYCLES-1. cnt clears on leaving an access state; it never wraps.

Test Plan:
- Fetch only, N=2: if_req=1, if_addr=16'h0010, SRAM returns 16'h4A05 -> IF_ACC in cycles 1-2; if_valid=1 and if_inst=16'h4A05 in cycle 2; pc_keep=1 in cycles 0-1 and 0 in cycle 2; IDLE in cycle 3.
- Contention: if_req and mem_rd both high in IDLE, mem_addr=16'h8000 -> MEM_RD first, mem_rdata=sram_dq_i=16'h1234 with mem_done in cycle 2; IF granted in cycle 3 with if_valid in cycle 5; pc_keep high through cycle 4.
- Store, N=3: mem_wr=1, mem_addr=16'h00FF, mem_wdata=16'hBEEF -> sram_we_n=0 in cycles 1-2 and 1 in cycle 3; sram_dq_oe=1 in cycles 1-3; mem_stall high in cycles 0-2 and low in cycle 3.
- Flush in cycle 1 of IF_ACC -> if_valid stays 0 and pc_keep=0 that cycle; IDLE next cycle; the next fetch uses the new if_addr.
- Both mem_rd and mem_wr high -> a write is performed and no read capture occurs (mem_rdata hold register unchanged).
- rst=1 in cycle 1 of MEM_WR -> all strobes high and sram_dq_oe=0 from the next edge; mem_done never asserts; IDLE afterwards.
